// File: rtl/regfile_writeback.sv
// regfile_writeback: owns the register file's single write port.
// Merges ALU results with FIFO-buffered load results and reports pending writes.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   alu_valid/alu_reg/alu_data  ALU result, always accepted
//   mem_valid/mem_ready         load result handshake
//   mem_reg/mem_data            load destination and data
//   RegWrite/write_reg/write_data  registered register-file write port
//   query1/query2, pend1/pend2  decode read addresses and their pending flags
//   fifo_count                  occupied FIFO entries (squashed ones included)
module regfile_writeback #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    input  logic [AW-1:0]          alu_reg,
    input  logic [DW-1:0]          alu_data,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [AW-1:0]          mem_reg,
    input  logic [DW-1:0]          mem_data,
    output logic                   RegWrite,
    output logic [AW-1:0]          write_reg,
    output logic [DW-1:0]          write_data,
    input  logic [AW-1:0]          query1,
    input  logic [AW-1:0]          query2,
    output logic                   pend1,
    output logic                   pend2,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    ent_reg  [DEPTH];
    logic [DW-1:0]    ent_data [DEPTH];
    // Set = stored and not squashed; cleared on pop so free slots never match.
    logic [DEPTH-1:0] ent_vld;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    logic alu_fire;
    logic push;
    logic store;
    logic pop;
    logic head_vld;

    assign mem_ready = !rst && (fifo_count < CW'(DEPTH));
    assign alu_fire  = alu_valid && (alu_reg != '0);
    assign push      = mem_valid && mem_ready;
    assign store     = push && (mem_reg != '0);
    assign pop       = !alu_fire && (fifo_count != '0);
    assign head_vld  = ent_vld[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite   <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else if (alu_fire) begin
            RegWrite   <= 1'b1;
            write_reg  <= alu_reg;
            write_data <= alu_data;
        end else if (pop) begin
            // A squashed head still consumes the slot but issues no write.
            RegWrite <= head_vld;
            if (head_vld) begin
                write_reg  <= ent_reg[rd_ptr];
                write_data <= ent_data[rd_ptr];
            end
        end else begin
            RegWrite <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (store) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            fifo_count <= fifo_count + CW'(store) - CW'(pop);
        end
    end

    // The ALU result is younger than every buffered load, so older loads to
    // the same register must never overwrite it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_vld <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pop && rd_ptr == PW'(i))
                    ent_vld[i] <= 1'b0;
                if (alu_fire && ent_reg[i] == alu_reg)
                    ent_vld[i] <= 1'b0;
                if (store && wr_ptr == PW'(i))
                    ent_vld[i] <= !(alu_fire && mem_reg == alu_reg);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            ent_reg[wr_ptr]  <= mem_reg;
            ent_data[wr_ptr] <= mem_data;
        end
    end

    always_comb begin
        pend1 = RegWrite && (write_reg == query1);
        pend2 = RegWrite && (write_reg == query2);
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && ent_reg[i] == query1) pend1 = 1'b1;
            if (ent_vld[i] && ent_reg[i] == query2) pend2 = 1'b1;
        end
        if (query1 == '0) pend1 = 1'b0;
        if (query2 == '0) pend2 = 1'b0;
    end

endmodule
